// File: rtl/alu_cmd_capture.sv
// Pushbutton/switch front end for the 5-bit ALU: debounced key events, operand capture, command
// issue over valid/ready. Define DIV_ZERO_GUARD_EN to refuse DIV commands with a zero divisor.
module alu_cmd_capture #(
  parameter int unsigned DATA_W          = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*DATA_W-1:0] sw_in,
  input  logic [1:0]          key_in,
  input  logic                cmd_ready,
  output logic                cmd_valid,
  output logic [DATA_W-1:0]   op_a,
  output logic [DATA_W-1:0]   op_b,
  output logic [1:0]          opcode,
  output logic                busy,
  output logic                err
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSelect, StIssue} state_e;

  logic [1:0] press;

  for (genvar g = 0; g < 2; g++) begin : g_key
    logic            sync1_q, sync2_q, db_q, db_dly_q, press_q;
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_q  <= 1'b1;
        sync2_q  <= 1'b1;
        db_q     <= 1'b1;
        db_dly_q <= 1'b1;
        press_q  <= 1'b0;
        cnt_q    <= '0;
      end else begin
        sync1_q  <= key_in[g];
        sync2_q  <= sync1_q;
        db_dly_q <= db_q;
        // Keys are active-low: a falling debounced level is a press.
        press_q  <= db_dly_q & ~db_q;
        if (sync2_q == db_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CntMax) begin
          db_q  <= sync2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign press[g] = press_q;
  end

  logic [2*DATA_W-1:0] sw_s1_q, sw_s2_q;
  state_e              state_q;
  logic                enter, next_op;

  assign enter   = press[0];
  assign next_op = press[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= sw_in;
      sw_s2_q <= sw_s1_q;
    end
  end

`ifdef DIV_ZERO_GUARD_EN
  logic err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cmd_valid <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      opcode    <= 2'b00;
`ifdef DIV_ZERO_GUARD_EN
      err_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enter) begin
            op_a    <= sw_s2_q[2*DATA_W-1:DATA_W];
            op_b    <= sw_s2_q[DATA_W-1:0];
            state_q <= StSelect;
`ifdef DIV_ZERO_GUARD_EN
            err_q   <= 1'b0;
`endif
          end
        end
        StSelect: begin
          if (enter) begin
`ifdef DIV_ZERO_GUARD_EN
            if (opcode == 2'b11 && op_b == '0) begin
              err_q <= 1'b1;
            end else begin
              err_q     <= 1'b0;
              cmd_valid <= 1'b1;
              state_q   <= StIssue;
            end
`else
            cmd_valid <= 1'b1;
            state_q   <= StIssue;
`endif
          end else if (next_op) begin
            opcode <= opcode + 2'd1;
          end
        end
        StIssue: begin
          // Key events here are dropped; operands and opcode stay put until accepted.
          if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: begin
          cmd_valid <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_alu_cmd_capture.sv
// Bench for alu_cmd_capture with a short debounce window: directed table, timing corner
// sequences, then random key/switch activity against a command-level model.
module tb_alu_cmd_capture;

  localparam int D     = 4;
  localparam int EvLat = D + 3 + 1;  // key event latency plus the FSM edge that makes busy visible
`ifdef DIV_ZERO_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] sw_in = '0;
  logic [1:0] key_in = 2'b11;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid, busy, err;
  logic [4:0] op_a, op_b;
  logic [1:0] opcode;

  alu_cmd_capture #(
    .DATA_W         (5),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw_in    (sw_in),
    .key_in   (key_in),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .op_a     (op_a),
    .op_b     (op_b),
    .opcode   (opcode),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] keys;  // pressed-key mask; 00 means a one-cycle cmd_ready pulse instead
    logic [9:0] sw;
    logic       busy;
    logic       cv;
    logic [4:0] a;
    logic [4:0] b;
    logic [1:0] op;
    logic       e;
  } vec_t;

  vec_t vecs[15];

  int         m_st;  // 0 idle, 1 select, 2 issue
  logic [4:0] m_a, m_b;
  logic [1:0] m_op;
  logic       m_err;

  function automatic vec_t mk(logic [1:0] keys, logic [9:0] sw, logic bz, logic cv,
                              logic [4:0] a, logic [4:0] b, logic [1:0] op, logic e);
    vec_t v;
    v.keys = keys; v.sw = sw; v.busy = bz; v.cv = cv; v.a = a; v.b = b; v.op = op; v.e = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic bz, input logic cv, input logic [4:0] a,
                            input logic [4:0] b, input logic [1:0] op, input logic e);
    check({tag, ".busy"}, 32'(busy), 32'(bz));
    check({tag, ".cmd_valid"}, 32'(cmd_valid), 32'(cv));
    check({tag, ".op_a"}, 32'(op_a), 32'(a));
    check({tag, ".op_b"}, 32'(op_b), 32'(b));
    check({tag, ".opcode"}, 32'(opcode), 32'(op));
    check({tag, ".err"}, 32'(err), 32'(e));
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [1:0] mask);
    key_in = ~mask;
    tick(10);
    key_in = 2'b11;
    tick(12);
  endtask

  task automatic accept();
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    tick(2);
  endtask

  task automatic act(input logic [1:0] keys);
    if (keys == 2'b00) accept();
    else press(keys);
  endtask

  // Cycles from the current negedge until busy is seen high (bounded).
  task automatic measure(input string name, input int exp);
    int n = 0;
    while (n < 40 && !busy) begin
      tick(1);
      n++;
    end
    check(name, 32'(n), 32'(exp));
  endtask

  task automatic model_reset();
    m_st = 0; m_a = '0; m_b = '0; m_op = 2'b00; m_err = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] keys, input logic [9:0] sw);
    if (keys == 2'b00) begin
      if (m_st == 2) m_st = 0;
    end else begin
      case (m_st)
        0: if (keys[0]) begin
          m_a = sw[9:5]; m_b = sw[4:0]; m_err = 1'b0; m_st = 1;
        end
        1: if (keys[0]) begin
          if (Guard && m_op == 2'd3 && m_b == 5'd0) m_err = 1'b1;
          else begin m_st = 2; m_err = 1'b0; end
        end else if (keys[1]) begin
          m_op = m_op + 2'd1;
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = mk(2'b01, 10'h3E0, 1, 0, 31, 0, 0, 0);
    vecs[1]  = mk(2'b10, 10'h155, 1, 0, 31, 0, 1, 0);
    vecs[2]  = mk(2'b10, 10'h155, 1, 0, 31, 0, 2, 0);
    vecs[3]  = mk(2'b10, 10'h155, 1, 0, 31, 0, 3, 0);
    vecs[4]  = mk(2'b10, 10'h155, 1, 0, 31, 0, 0, 0);
    vecs[5]  = mk(2'b10, 10'h155, 1, 0, 31, 0, 1, 0);
    vecs[6]  = mk(2'b11, 10'h155, 1, 1, 31, 0, 1, 0);
    vecs[7]  = mk(2'b00, 10'h155, 0, 0, 31, 0, 1, 0);
    vecs[8]  = mk(2'b01, 10'h060, 1, 0, 3, 0, 1, 0);
    vecs[9]  = mk(2'b10, 10'h155, 1, 0, 3, 0, 2, 0);
    vecs[10] = mk(2'b10, 10'h155, 1, 0, 3, 0, 3, 0);
`ifdef DIV_ZERO_GUARD_EN
    vecs[11] = mk(2'b01, 10'h155, 1, 0, 3, 0, 3, 1);
    vecs[12] = mk(2'b10, 10'h155, 1, 0, 3, 0, 0, 1);
    vecs[13] = mk(2'b01, 10'h155, 1, 1, 3, 0, 0, 0);
    vecs[14] = mk(2'b00, 10'h155, 0, 0, 3, 0, 0, 0);
`else
    vecs[11] = mk(2'b01, 10'h155, 1, 1, 3, 0, 3, 0);
    vecs[12] = mk(2'b10, 10'h155, 1, 1, 3, 0, 3, 0);
    vecs[13] = mk(2'b01, 10'h155, 1, 1, 3, 0, 3, 0);
    vecs[14] = mk(2'b00, 10'h155, 0, 0, 3, 0, 3, 0);
`endif

    // Reset values, then capture/issue with a measured enter latency.
    rst = 1'b1;
    sw_in = 10'b00001_00010;
    tick(3);
    rst = 1'b0;
    tick(1);
    check_outs("reset", 0, 0, 0, 0, 0, 0);

    key_in = 2'b10;
    measure("enter_latency", EvLat);
    tick(3);
    key_in = 2'b11;
    tick(12);
    check_outs("capture", 1, 0, 1, 2, 0, 0);

    sw_in = 10'h3FF;
    press(2'b01);
    check_outs("issue", 1, 1, 1, 2, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_outs($sformatf("hold%0d", i), 1, 1, 1, 2, 0, 0);
    end
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    check("after_ready.cmd_valid", 32'(cmd_valid), 32'(0));
    check("after_ready.busy", 32'(busy), 32'(0));

    // Opcode stepping, simultaneous keys, divide-by-zero handling.
    for (int i = 0; i < 15; i++) begin
      sw_in = vecs[i].sw;
      act(vecs[i].keys);
      check_outs($sformatf("vec%0d", i), vecs[i].busy, vecs[i].cv, vecs[i].a, vecs[i].b,
                 vecs[i].op, vecs[i].e);
    end

    // Reset while a command is pending.
    sw_in = 10'h0A5;
    press(2'b01);
    press(2'b01);
    check("pre_rst.cmd_valid", 32'(cmd_valid), 32'(1));
    rst = 1'b1;
    tick(1);
    check_outs("mid_issue_rst", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick(12);

    // Bounce: 2-cycle phases must be filtered; the final held-low edge yields one event.
    for (int i = 0; i < 10; i++) begin
      key_in[0] = (i % 2 == 1);
      tick(2);
      check($sformatf("bounce_phase%0d.busy", i), 32'(busy), 32'(0));
    end
    key_in[0] = 1'b0;
    measure("bounce_latency", EvLat);
    tick(5);
    key_in[0] = 1'b1;
    tick(12);
    check("bounce_single.busy", 32'(busy), 32'(1));
    check("bounce_single.cmd_valid", 32'(cmd_valid), 32'(0));

    // Key held low through reset is reported once reset is released.
    key_in[0] = 1'b0;
    rst = 1'b1;
    tick(3);
    check("rst_hold.busy", 32'(busy), 32'(0));
    rst = 1'b0;
    measure("rst_held_latency", EvLat);
    tick(3);
    key_in[0] = 1'b1;
    tick(12);

    // Random key/switch activity against the command-level model.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    model_reset();
    for (int it = 0; it < 60; it++) begin
      int unsigned r;
      logic [9:0]  sw;
      logic [1:0]  keys;
      r  = $urandom_range(0, 8);
      sw = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 2) == 0) sw[4:0] = 5'd0;
      keys = (r < 3) ? 2'b01 : (r < 6) ? 2'b10 : (r == 6) ? 2'b11 : 2'b00;
      sw_in = sw;
      act(keys);
      model_step(keys, sw);
      check_outs($sformatf("rand%0d", it), m_st != 0, m_st == 2, m_a, m_b, m_op, m_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
